// File: rtl/half_fp_add_align.sv
`default_nettype none
// ============================================================================
//  Module      : half_fp_add_align
//  Description : Operand-alignment front end of the FP16 adder. Two operands
//                and an add/sub select are unpacked and classified. They are
//                ordered by magnitude, and the smaller significand is shifted
//                right to the larger exponent with guard/round/sticky bits.
//                Structure is a two-stage valid/ready pipeline: it accepts one
//                operation per cycle and produces the result two cycles later.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1      clock, rising edge
//    rst          in   1      synchronous reset, active low (0 = reset)
//    in_valid     in   1      operands valid
//    in_ready     out  1      stage can accept (transfer on valid & ready)
//    float1       in   16     FP16 operand 1
//    float2       in   16     FP16 operand 2
//    op_sub       in   1      1: float1 - float2 (sign of float2 inverted)
//    out_valid    out  1      aligned result valid
//    out_ready    in   1      consumer accepts (transfer on valid & ready)
//    sign_big     out  1      sign of larger-magnitude operand
//    sign_small   out  1      sign of smaller-magnitude operand
//    exp_big      out  EXP_W  effective exponent of larger operand
//    mant_big     out  AW     {hidden, mantissa, 3'b000} of larger operand
//    mant_small   out  AW     aligned smaller significand with sticky in bit 0
//    eff_sub      out  1      effective subtraction (sign_big ^ sign_small)
//    special      out  1      result fully determined by this stage
//    special_res  out  16     result when special = 1, else 0
// ============================================================================
module half_fp_add_align #(
    parameter int          EXP_W = 5,
    parameter int          MAN_W = 10,
    parameter logic [15:0] QNAN  = 16'h7E00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        float1,
    input  logic [15:0]        float2,
    input  logic               op_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sign_big,
    output logic               sign_small,
    output logic [EXP_W-1:0]   exp_big,
    output logic [MAN_W+3:0]   mant_big,
    output logic [MAN_W+3:0]   mant_small,
    output logic               eff_sub,
    output logic               special,
    output logic [15:0]        special_res
);

    // Aligned significand width (hidden + mantissa + G,R,S) and
    // significand width without the alignment bits.
    localparam int c_AW = MAN_W + 4;
    localparam int c_SW = MAN_W + 1;

    // Magnitude field of an infinity (all-ones exponent, zero mantissa).
    localparam logic [EXP_W+MAN_W-1:0] c_INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_adv;
    logic w_s1_adv;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = rst && w_s1_adv;

    // ------------------------------------------------------------------
    // Stage 1 combinational: unpack, classify, order, special detection
    // ------------------------------------------------------------------
    logic               w_sign1;
    logic               w_sign2;
    logic [EXP_W-1:0]   w_exp1;
    logic [EXP_W-1:0]   w_exp2;
    logic [MAN_W-1:0]   w_man1;
    logic [MAN_W-1:0]   w_man2;
    logic               w_hid1;
    logic               w_hid2;
    logic [EXP_W-1:0]   w_eexp1;
    logic [EXP_W-1:0]   w_eexp2;
    logic [c_SW-1:0]    w_sig1;
    logic [c_SW-1:0]    w_sig2;

    assign w_sign1 = float1[15];
    assign w_sign2 = float2[15] ^ op_sub;
    assign w_exp1  = float1[MAN_W+EXP_W-1:MAN_W];
    assign w_exp2  = float2[MAN_W+EXP_W-1:MAN_W];
    assign w_man1  = float1[MAN_W-1:0];
    assign w_man2  = float2[MAN_W-1:0];

    // Subnormals carry no hidden bit but share the exponent of the
    // smallest normal, so their effective exponent is 1.
    assign w_hid1  = |w_exp1;
    assign w_hid2  = |w_exp2;
    assign w_eexp1 = w_hid1 ? w_exp1 : EXP_W'(1);
    assign w_eexp2 = w_hid2 ? w_exp2 : EXP_W'(1);
    assign w_sig1  = {w_hid1, w_man1};
    assign w_sig2  = {w_hid2, w_man2};

    // Classification
    logic w_expmax1;
    logic w_expmax2;
    logic w_nan1;
    logic w_nan2;
    logic w_inf1;
    logic w_inf2;
    logic w_zero1;
    logic w_zero2;

    assign w_expmax1 = &w_exp1;
    assign w_expmax2 = &w_exp2;
    assign w_nan1    = w_expmax1 && (|w_man1);
    assign w_nan2    = w_expmax2 && (|w_man2);
    assign w_inf1    = w_expmax1 && !(|w_man1);
    assign w_inf2    = w_expmax2 && !(|w_man2);
    assign w_zero1   = !w_hid1 && !(|w_man1);
    assign w_zero2   = !w_hid2 && !(|w_man2);

    // Magnitude ordering: {exp, mant} compares as an unsigned integer.
    // On a tie float1 is taken as the larger operand.
    logic w_one_big;
    assign w_one_big = {w_exp1, w_man1} >= {w_exp2, w_man2};

    logic               w_sign_big;
    logic               w_sign_small;
    logic [EXP_W-1:0]   w_eexp_big;
    logic [EXP_W-1:0]   w_eexp_small;
    logic [c_SW-1:0]    w_sig_big;
    logic [c_SW-1:0]    w_sig_small;
    logic [EXP_W-1:0]   w_diff;

    assign w_sign_big   = w_one_big ? w_sign1 : w_sign2;
    assign w_sign_small = w_one_big ? w_sign2 : w_sign1;
    assign w_eexp_big   = w_one_big ? w_eexp1 : w_eexp2;
    assign w_eexp_small = w_one_big ? w_eexp2 : w_eexp1;
    assign w_sig_big    = w_one_big ? w_sig1  : w_sig2;
    assign w_sig_small  = w_one_big ? w_sig2  : w_sig1;
    // The ordering guarantees this never underflows.
    assign w_diff       = w_eexp_big - w_eexp_small;

    // Special results in precedence order.
    logic        w_special;
    logic [15:0] w_special_res;

    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
        if (w_nan1 || w_nan2) begin
            w_special     = 1'b1;
            w_special_res = QNAN;
        end else if (w_inf1 && w_inf2) begin
            w_special     = 1'b1;
            // Opposite-signed infinities (after op_sub) are invalid.
            w_special_res = (w_sign1 != w_sign2) ? QNAN : {w_sign1, c_INF_MAG};
        end else if (w_inf1) begin
            w_special     = 1'b1;
            w_special_res = {w_sign1, c_INF_MAG};
        end else if (w_inf2) begin
            w_special     = 1'b1;
            w_special_res = {w_sign2, c_INF_MAG};
        end else if (w_zero1 && w_zero2) begin
            // Round-to-nearest: -0 only when both addends are -0.
            w_special     = 1'b1;
            w_special_res = {w_sign1 && w_sign2, {(EXP_W+MAN_W){1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic               r_s1_sign_big;
    logic               r_s1_sign_small;
    logic [EXP_W-1:0]   r_s1_eexp_big;
    logic [c_SW-1:0]    r_s1_sig_big;
    logic [c_SW-1:0]    r_s1_sig_small;
    logic [EXP_W-1:0]   r_s1_diff;
    logic               r_s1_special;
    logic [15:0]        r_s1_special_res;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid       <= 1'b0;
            r_s1_sign_big    <= 1'b0;
            r_s1_sign_small  <= 1'b0;
            r_s1_eexp_big    <= '0;
            r_s1_sig_big     <= '0;
            r_s1_sig_small   <= '0;
            r_s1_diff        <= '0;
            r_s1_special     <= 1'b0;
            r_s1_special_res <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign_big    <= w_sign_big;
                r_s1_sign_small  <= w_sign_small;
                r_s1_eexp_big    <= w_eexp_big;
                r_s1_sig_big     <= w_sig_big;
                r_s1_sig_small   <= w_sig_small;
                r_s1_diff        <= w_diff;
                r_s1_special     <= w_special;
                r_s1_special_res <= w_special_res;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: right shift with sticky collection
    // ------------------------------------------------------------------
    logic [c_AW-1:0] w_sig_ext;
    logic [c_AW-1:0] w_shifted;
    logic [c_AW-1:0] w_lost_mask;
    logic            w_sticky;
    logic [c_AW-1:0] w_mant_small;

    assign w_sig_ext = {r_s1_sig_small, 3'b000};

    always_comb begin
        w_shifted    = '0;
        w_lost_mask  = '0;
        w_sticky     = 1'b0;
        w_mant_small = '0;
        if (32'(r_s1_diff) >= 32'(c_AW)) begin
            // Everything is shifted out; only the sticky survives.
            w_sticky     = |r_s1_sig_small;
            w_mant_small = {{(c_AW-1){1'b0}}, w_sticky};
        end else begin
            w_shifted    = w_sig_ext >> r_s1_diff;
            w_lost_mask  = ~({c_AW{1'b1}} << r_s1_diff);
            w_sticky     = |(w_sig_ext & w_lost_mask);
            w_mant_small = w_shifted | {{(c_AW-1){1'b0}}, w_sticky};
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (drive the outputs directly)
    // ------------------------------------------------------------------
    logic               r_s2_sign_big;
    logic               r_s2_sign_small;
    logic [EXP_W-1:0]   r_s2_exp_big;
    logic [c_AW-1:0]    r_s2_mant_big;
    logic [c_AW-1:0]    r_s2_mant_small;
    logic               r_s2_special;
    logic [15:0]        r_s2_special_res;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s2_valid       <= 1'b0;
            r_s2_sign_big    <= 1'b0;
            r_s2_sign_small  <= 1'b0;
            r_s2_exp_big     <= '0;
            r_s2_mant_big    <= '0;
            r_s2_mant_small  <= '0;
            r_s2_special     <= 1'b0;
            r_s2_special_res <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign_big    <= r_s1_sign_big;
                r_s2_sign_small  <= r_s1_sign_small;
                r_s2_exp_big     <= r_s1_eexp_big;
                r_s2_mant_big    <= {r_s1_sig_big, 3'b000};
                r_s2_mant_small  <= w_mant_small;
                r_s2_special     <= r_s1_special;
                r_s2_special_res <= r_s1_special_res;
            end
        end
    end

    assign out_valid   = r_s2_valid;
    assign sign_big    = r_s2_sign_big;
    assign sign_small  = r_s2_sign_small;
    assign exp_big     = r_s2_exp_big;
    assign mant_big    = r_s2_mant_big;
    assign mant_small  = r_s2_mant_small;
    assign eff_sub     = r_s2_sign_big ^ r_s2_sign_small;
    assign special     = r_s2_special;
    assign special_res = r_s2_special_res;

endmodule
`default_nettype wire

// File: tb/tb_half_fp_add_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_half_fp_add_align
//  Description : Self-checking bench for half_fp_add_align. Accepted inputs
//                and emitted outputs are recorded at the falling edge; each
//                test task compares emitted results against a behavioural
//                arithmetic model of the alignment rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_half_fp_add_align;

    typedef struct packed {
        logic [15:0] f1;
        logic [15:0] f2;
        logic        sub;
    } op_t;

    typedef struct packed {
        logic        sign_big;
        logic        sign_small;
        logic [4:0]  exp_big;
        logic [13:0] mant_big;
        logic [13:0] mant_small;
        logic        eff_sub;
        logic        special;
        logic [15:0] special_res;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] float1 = '0;
    logic [15:0] float2 = '0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        sign_big;
    logic        sign_small;
    logic [4:0]  exp_big;
    logic [13:0] mant_big;
    logic [13:0] mant_small;
    logic        eff_sub;
    logic        special;
    logic [15:0] special_res;

    int n_tests = 0;
    int n_fail  = 0;

    op_t  in_q[$];
    res_t out_q[$];

    half_fp_add_align dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .float1      (float1),
        .float2      (float2),
        .op_sub      (op_sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sign_big    (sign_big),
        .sign_small  (sign_small),
        .exp_big     (exp_big),
        .mant_big    (mant_big),
        .mant_small  (mant_small),
        .eff_sub     (eff_sub),
        .special     (special),
        .special_res (special_res)
    );

    always #5 clk = ~clk;

    function automatic res_t cur_out();
        return {sign_big, sign_small, exp_big, mant_big, mant_small,
                eff_sub, special, special_res};
    endfunction

    // Transfers happen at the next rising edge; signals are stable here.
    always @(negedge clk) begin
        if (rst) begin
            if (in_valid && in_ready) in_q.push_back({float1, float2, op_sub});
            if (out_valid && out_ready) out_q.push_back(cur_out());
        end
    end

    // Behavioural model: integer arithmetic on the FP16 fields.
    function automatic res_t model(op_t op);
        res_t   r;
        int     e1, e2, m1, m2, ee1, ee2, sg1, sg2, mag1, mag2;
        int     eb, diff, sgb, sgs;
        bit     s1, s2, sb, ss, one_big;
        longint ext, p, q, rem;
        s1 = op.f1[15];
        s2 = op.f2[15] ^ op.sub;
        e1 = int'(op.f1[14:10]);
        e2 = int'(op.f2[14:10]);
        m1 = int'(op.f1[9:0]);
        m2 = int'(op.f2[9:0]);
        ee1 = (e1 == 0) ? 1 : e1;
        ee2 = (e2 == 0) ? 1 : e2;
        sg1 = ((e1 != 0) ? 1024 : 0) + m1;
        sg2 = ((e2 != 0) ? 1024 : 0) + m2;
        mag1 = e1 * 1024 + m1;
        mag2 = e2 * 1024 + m2;
        one_big = (mag1 >= mag2);
        sb  = one_big ? s1 : s2;
        ss  = one_big ? s2 : s1;
        eb  = one_big ? ee1 : ee2;
        sgb = one_big ? sg1 : sg2;
        sgs = one_big ? sg2 : sg1;
        diff = eb - (one_big ? ee2 : ee1);
        ext = longint'(sgs) * 8;
        p   = longint'(1) << diff;
        q   = ext / p;
        rem = ext % p;
        r.sign_big    = sb;
        r.sign_small  = ss;
        r.exp_big     = 5'(eb);
        r.mant_big    = 14'(sgb * 8);
        r.mant_small  = 14'(q | ((rem != 0) ? 1 : 0));
        r.eff_sub     = sb ^ ss;
        r.special     = 1'b1;
        if ((e1 == 31 && m1 != 0) || (e2 == 31 && m2 != 0))
            r.special_res = 16'h7E00;
        else if (e1 == 31 && e2 == 31)
            r.special_res = (s1 != s2) ? 16'h7E00 : {s1, 15'h7C00};
        else if (e1 == 31)
            r.special_res = {s1, 15'h7C00};
        else if (e2 == 31)
            r.special_res = {s2, 15'h7C00};
        else if (mag1 == 0 && mag2 == 0)
            r.special_res = {s1 & s2, 15'h0000};
        else begin
            r.special     = 1'b0;
            r.special_res = 16'h0000;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_fp();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 9))
            0: v[14:10] = 5'h00;
            1: v[14:10] = 5'h1F;
            2: v[14:0]  = 15'h0000;
            3: v[9:0]   = 10'h000;
            default: ;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        float1 = 16'h3C00; float2 = 16'h3C00; op_sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_tests++;
        if (cur_out() !== res_t'(0)) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", cur_out());
        end
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
        in_q.delete(); out_q.delete();
    endtask

    task automatic test_directed();
        op_t  vec[11];
        res_t exp_r;
        res_t got;
        vec[0]  = {16'h3C00, 16'h3C00, 1'b0};
        vec[1]  = {16'h3C00, 16'h1400, 1'b0};
        vec[2]  = {16'h1400, 16'hBC00, 1'b0};
        vec[3]  = {16'h7BFF, 16'h0001, 1'b0};
        vec[4]  = {16'h3C01, 16'h3401, 1'b0};
        vec[5]  = {16'h7C00, 16'hFC00, 1'b0};
        vec[6]  = {16'h7C00, 16'h7C00, 1'b1};
        vec[7]  = {16'h7E01, 16'h3C00, 1'b0};
        vec[8]  = {16'h7C00, 16'h3C00, 1'b0};
        vec[9]  = {16'h8000, 16'h8000, 1'b0};
        vec[10] = {16'h8000, 16'h8000, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            {float1, float2, op_sub} = vec[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL latency_early[%0d]: out_valid got %b expected 0", i, out_valid);
            end
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1) begin
                n_fail++; $display("FAIL latency_due[%0d]: out_valid got %b expected 1", i, out_valid);
            end
            exp_r = model(vec[i]);
            got   = cur_out();
            n_tests++;
            if (got !== exp_r) begin
                n_fail++; $display("FAIL directed[%0d]: got %h expected %h", i, got, exp_r);
            end
            // Hand-derived values for selected vectors.
            if (i == 0) begin
                n_tests++;
                if ({exp_big, mant_big, mant_small, eff_sub, special} !== {5'd15, 14'h2000, 14'h2000, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL one_plus_one: got %0d %h %h %b %b expected 15 2000 2000 0 0",
                             exp_big, mant_big, mant_small, eff_sub, special);
                end
            end
            if (i == 2) begin
                n_tests++;
                if ({sign_big, eff_sub, mant_small} !== {1'b1, 1'b1, 14'h0008}) begin
                    n_fail++;
                    $display("FAIL sub_order: got %b %b %h expected 1 1 0008", sign_big, eff_sub, mant_small);
                end
            end
            if (i == 3) begin
                n_tests++;
                if ({exp_big, mant_small} !== {5'd30, 14'h0001}) begin
                    n_fail++;
                    $display("FAIL far_shift: got %0d %h expected 30 0001", exp_big, mant_small);
                end
            end
            if (i == 6) begin
                n_tests++;
                if ({special, special_res} !== {1'b1, 16'h7E00}) begin
                    n_fail++;
                    $display("FAIL inf_minus_inf: got %b %h expected 1 7e00", special, special_res);
                end
            end
            if (i == 9) begin
                n_tests++;
                if ({special, special_res} !== {1'b1, 16'h8000}) begin
                    n_fail++;
                    $display("FAIL negzero_sum: got %b %h expected 1 8000", special, special_res);
                end
            end
        end
        @(negedge clk);
        in_q.delete(); out_q.delete();
    endtask

    task automatic test_random();
        int   sent  = 0;
        int   guard = 0;
        bit   hold  = 0;
        op_t  op;
        res_t got;
        while (sent < 300 && guard < 5000) begin
            guard++;
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    float1 = rand_fp();
                    float2 = ($urandom_range(0, 5) == 0) ? float1 : rand_fp();
                    op_sub = 1'($urandom);
                    hold = 1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                hold = 0;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && out_q.size() < in_q.size(); i++) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (sent != 300 || out_q.size() != in_q.size()) begin
            n_fail++;
            $display("FAIL random_count: sent %0d emitted %0d accepted %0d expected 300 each",
                     sent, out_q.size(), in_q.size());
        end
        while (out_q.size() > 0 && in_q.size() > 0) begin
            op  = in_q.pop_front();
            got = out_q.pop_front();
            n_tests++;
            if (got !== model(op)) begin
                n_fail++;
                $display("FAIL random %h %h sub=%b: got %h expected %h", op.f1, op.f2, op.sub, got, model(op));
            end
        end
        in_q.delete(); out_q.delete();
    endtask

    task automatic test_backpressure();
        op_t  ops[6];
        int   idx = 0;
        res_t got;
        for (int i = 0; i < 6; i++) ops[i] = {rand_fp(), rand_fp(), 1'($urandom)};
        for (int cyc = 0; cyc < 60 && idx < 6; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 4);
            in_valid  = 1'b1;
            {float1, float2, op_sub} = ops[idx];
            @(negedge clk);
            if (cyc == 2 || cyc == 3) begin
                n_tests++;
                if (in_ready !== 1'b0 || idx != 2) begin
                    n_fail++;
                    $display("FAIL bp_full[%0d]: in_ready %b accepted %0d expected 0 and 2", cyc, in_ready, idx);
                end
                n_tests++;
                if (out_valid !== 1'b1 || cur_out() !== model(ops[0])) begin
                    n_fail++;
                    $display("FAIL bp_hold[%0d]: got %b %h expected 1 %h", cyc, out_valid, cur_out(), model(ops[0]));
                end
            end
            if (in_valid && in_ready) idx++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && out_q.size() < 6; i++) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (out_q.size() != 6) begin
            n_fail++; $display("FAIL bp_count: got %0d expected 6", out_q.size());
        end
        for (int i = 0; i < 6 && out_q.size() > 0; i++) begin
            got = out_q.pop_front();
            n_tests++;
            if (got !== model(ops[i])) begin
                n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got, model(ops[i]));
            end
        end
        in_q.delete(); out_q.delete();
    endtask

    task automatic test_reset_mid();
        op_t  op;
        res_t got;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; float1 = 16'h4000; float2 = 16'h3C00; op_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_prefill: out_valid got %b expected 1", out_valid);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || cur_out() !== res_t'(0)) begin
            n_fail++; $display("FAIL mid_reset_clear: got %b %h expected 0 0", out_valid, cur_out());
        end
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b1;
        in_q.delete(); out_q.delete();
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (out_q.size() != 0) begin
            n_fail++; $display("FAIL mid_stale: emitted %0d expected 0", out_q.size());
        end
        @(posedge clk); #1;
        op = {16'hC500, 16'h3800, 1'b1};
        in_valid = 1'b1; {float1, float2, op_sub} = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10 && out_q.size() < 1; i++) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (out_q.size() != 1) begin
            n_fail++; $display("FAIL mid_recover_count: got %0d expected 1", out_q.size());
        end else begin
            got = out_q.pop_front();
            n_tests++;
            if (got !== model(op)) begin
                n_fail++; $display("FAIL mid_recover: got %h expected %h", got, model(op));
            end
        end
        in_q.delete(); out_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
